// File: rtl/gpu_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : gpu_frame_sequencer_if
// Description : Host shadow-config write bus plus the GPU launch/frame-end
//               handshake. The master side is the frame sequencer; the slave
//               side is the host/GPU pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpu_frame_sequencer_if #(
    parameter int MAT_W = 18
);
    // Host shadow-configuration write port
    logic                    cfg_wr_en;
    logic [4:0]              cfg_wr_addr;
    logic [31:0]             cfg_wr_data;

    // GPU launch handshake and active configuration
    logic                    gpu_start;
    logic [31:0]             gpu_vertex_count;
    logic signed [MAT_W-1:0] gpu_transform_matrix [0:15];
    logic                    gpu_frame_end;

    modport master (
        input  cfg_wr_en,
        input  cfg_wr_addr,
        input  cfg_wr_data,
        input  gpu_frame_end,
        output gpu_start,
        output gpu_vertex_count,
        output gpu_transform_matrix
    );

    modport slave (
        output cfg_wr_en,
        output cfg_wr_addr,
        output cfg_wr_data,
        output gpu_frame_end,
        input  gpu_start,
        input  gpu_vertex_count,
        input  gpu_transform_matrix
    );
endinterface
`default_nettype wire

// File: rtl/gpu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gpu_frame_sequencer
// Description : Frame-level controller for the GPU. Double-buffers the render
//               configuration (shadow written by host, active driven to GPU),
//               launches frames on a vblank rising edge, commits shadow to
//               active only at launch, guards each frame with a timeout and
//               counts completed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_frame_sequencer #(
    parameter int MAT_W          = 18,
    parameter int FRAC_BITS      = 7,
    parameter int TIMEOUT_CYCLES = 16777215,
    parameter int USE_VBLANK     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    gpu_frame_sequencer_if.master bus,
    input  logic                  run,
    input  logic                  single_shot,
    input  logic                  vblank,
    input  logic                  err_clr,
    output logic                  busy,
    output logic [31:0]           frame_count,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value on the last cycle that is still inside the budget
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [MAT_W-1:0] ONE = MAT_W'(1 << FRAC_BITS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_VBL = 3'd1,
        S_LAUNCH   = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_RUN      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    vblank_q;
    logic signed [MAT_W-1:0] shd_mat_q [0:15];
    logic [31:0]             shd_vcnt_q;
    logic signed [MAT_W-1:0] act_mat_q [0:15];
    logic [31:0]             act_vcnt_q;
    logic                    start_q;
    logic                    busy_q;
    logic [31:0]             frame_cnt_q;
    logic                    to_err_q;
    logic [CNT_W-1:0]        tcnt_q;

    logic                    vbl_rise;
    logic                    launch_go;
    logic                    tmo_hit;

    // Identity-matrix entry for reset: diagonal positions are 0,5,10,15
    function automatic logic signed [MAT_W-1:0] ident_entry(input int idx);
        return ((idx % 5) == 0) ? ONE : '0;
    endfunction

    assign vbl_rise  = vblank & ~vblank_q;
    assign launch_go = (USE_VBLANK == 0) ? 1'b1 : vbl_rise;
    assign tmo_hit   = (tcnt_q == TO_LAST);

    // Shadow configuration: host writes land here in any state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                shd_mat_q[i] <= ident_entry(i);
            end
            shd_vcnt_q <= '0;
        end else if (bus.cfg_wr_en) begin
            if (!bus.cfg_wr_addr[4]) begin
                shd_mat_q[bus.cfg_wr_addr[3:0]] <= bus.cfg_wr_data[MAT_W-1:0];
            end else if (bus.cfg_wr_addr == 5'd16) begin
                shd_vcnt_q <= bus.cfg_wr_data;
            end
        end
    end

    // Frame FSM with registered outputs, active-config commit and timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            vblank_q    <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            to_err_q    <= 1'b0;
            tcnt_q      <= '0;
            act_vcnt_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                act_mat_q[i] <= ident_entry(i);
            end
        end else begin
            vblank_q <= vblank;
            start_q  <= 1'b0;
            // A timeout below overrides this clear in the same cycle
            if (err_clr) begin
                to_err_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (run || single_shot) begin
                        state_q <= S_WAIT_VBL;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT_VBL: begin
                    if (launch_go) begin
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // Active copy takes the pre-write shadow value
                    act_mat_q  <= shd_mat_q;
                    act_vcnt_q <= shd_vcnt_q;
                    tcnt_q     <= '0;
                    if (shd_vcnt_q[31:2] == 30'd0) begin
                        state_q <= S_DONE;
                    end else begin
                        start_q <= 1'b1;
                        state_q <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK, S_RUN: begin
                    if (tmo_hit) begin
                        to_err_q <= 1'b1;
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                        if ((state_q == S_WAIT_ACK) && !bus.gpu_frame_end) begin
                            state_q <= S_RUN;
                        end else if ((state_q == S_RUN) && bus.gpu_frame_end) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    frame_cnt_q <= frame_cnt_q + 32'd1;
                    if (run) begin
                        state_q <= S_WAIT_VBL;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gpu_start        = start_q;
    assign bus.gpu_vertex_count = act_vcnt_q;
    assign busy                 = busy_q;
    assign frame_count          = frame_cnt_q;
    assign timeout_err          = to_err_q;

    generate
        for (genvar g = 0; g < 16; g++) begin : g_mat_out
            assign bus.gpu_transform_matrix[g] = act_mat_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gpu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_frame_sequencer
// Description : Directed self-checking bench for gpu_frame_sequencer with a
//               small GPU model that drops frame_end after each launch and
//               raises it a programmable number of cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_frame_sequencer;

    localparam int MAT_W          = 18;
    localparam int FRAC_BITS      = 7;
    localparam int TIMEOUT_CYCLES = 64;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        run         = 1'b0;
    logic        single_shot = 1'b0;
    logic        vblank      = 1'b0;
    logic        err_clr     = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic [31:0] frame_count;

    gpu_frame_sequencer_if #(.MAT_W(MAT_W)) bus ();

    gpu_frame_sequencer #(
        .MAT_W          (MAT_W),
        .FRAC_BITS      (FRAC_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .USE_VBLANK     (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .run         (run),
        .single_shot (single_shot),
        .vblank      (vblank),
        .err_clr     (err_clr),
        .busy        (busy),
        .frame_count (frame_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // GPU model: frame_end drops the cycle after gpu_start, rises gpu_lat later
    int gpu_lat  = 50;
    bit gpu_hang = 1'b0;
    int gcnt     = 0;
    always @(negedge clk) begin
        if (reset) begin
            bus.gpu_frame_end = 1'b1;
            gcnt = 0;
        end else if (bus.gpu_start) begin
            bus.gpu_frame_end = 1'b0;
            gcnt = gpu_lat;
        end else if (gcnt > 0) begin
            gcnt--;
            if (gcnt == 0 && !gpu_hang) bus.gpu_frame_end = 1'b1;
        end
    end

    // Launch monitor: counts gpu_start cycles and captures the active config
    int          n_starts  = 0;
    int          start_cyc = 0;
    logic [31:0] cap_vc;
    logic [63:0] cap_m0, cap_m1, cap_m5;
    always @(negedge clk) begin
        if (bus.gpu_start) begin
            n_starts++;
            start_cyc = cyc;
            cap_vc = bus.gpu_vertex_count;
            cap_m0 = 64'(bus.gpu_transform_matrix[0]);
            cap_m1 = 64'(bus.gpu_transform_matrix[1]);
            cap_m5 = 64'(bus.gpu_transform_matrix[5]);
        end
    end

    int vbl_cyc = 0;
    int exp_fc  = 0;
    int base_st = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [4:0] addr, input logic [31:0] data);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = addr;
        bus.cfg_wr_data = data;
        tick();
        bus.cfg_wr_en   = 1'b0;
    endtask

    task automatic pulse_single();
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
    endtask

    task automatic vblank_edge(input int hold);
        vblank  = 1'b1;
        vbl_cyc = cyc;
        repeat (hold) tick();
        vblank  = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        bus.cfg_wr_en   = 1'b0;
        bus.cfg_wr_addr = '0;
        bus.cfg_wr_data = '0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_start", 64'(bus.gpu_start), 0);
        check_eq("rst_busy",  64'(busy), 0);
        check_eq("rst_fc",    64'(frame_count), 0);
        check_eq("rst_err",   64'(timeout_err), 0);
        check_eq("rst_vc",    64'(bus.gpu_vertex_count), 0);
        check_eq("rst_m0",    64'(bus.gpu_transform_matrix[0]), 128);
        check_eq("rst_m1",    64'(bus.gpu_transform_matrix[1]), 0);
        check_eq("rst_m15",   64'(bus.gpu_transform_matrix[15]), 128);
        reset = 1'b0;
        tick();

        // Single shot
        gpu_lat = 50;
        write_cfg(5'd16, 32'd100);
        write_cfg(5'd0, 32'd256);
        check_eq("ss_m0_not_yet", 64'(bus.gpu_transform_matrix[0]), 128);
        pulse_single();
        check_eq("ss_busy", 64'(busy), 1);
        vblank_edge(3);
        wait_idle("ss_idle", 200);
        exp_fc = 1;
        check_eq("ss_starts", 64'(n_starts), 1);
        check_eq("ss_latency", 64'(start_cyc - vbl_cyc), 2);
        check_eq("ss_cap_vc", 64'(cap_vc), 100);
        check_eq("ss_cap_m0", cap_m0, 256);
        check_eq("ss_fc", 64'(frame_count), 64'(exp_fc));

        // Continuous mode: three edges, last vblank held high
        gpu_lat = 20;
        base_st = n_starts;
        run = 1'b1;
        tick();
        check_eq("run_busy", 64'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            vblank  = 1'b1;
            vbl_cyc = cyc;
            if (i < 2) begin
                repeat (3) tick();
                vblank = 1'b0;
                repeat (37) tick();
            end else begin
                repeat (100) tick();
            end
            check_eq($sformatf("run_latency%0d", i), 64'(start_cyc - vbl_cyc), 2);
        end
        exp_fc += 3;
        check_eq("run_starts3", 64'(n_starts - base_st), 3);
        check_eq("run_fc3", 64'(frame_count), 64'(exp_fc));
        check_eq("run_waiting", 64'(busy), 1);
        // Fourth frame; run drops mid-frame so the sequencer then idles
        vblank = 1'b0;
        repeat (3) tick();
        vblank_edge(3);
        repeat (3) tick();
        run = 1'b0;
        wait_idle("run_stop_idle", 200);
        exp_fc += 1;
        check_eq("run_starts4", 64'(n_starts - base_st), 4);
        check_eq("run_fc4", 64'(frame_count), 64'(exp_fc));

        // Shadow isolation: mid-RUN write
        gpu_lat = 50;
        pulse_single();
        vblank_edge(3);
        repeat (10) tick();
        write_cfg(5'd5, 32'd77);
        check_eq("iso_m5_run_a", 64'(bus.gpu_transform_matrix[5]), 128);
        repeat (5) tick();
        check_eq("iso_m5_run_b", 64'(bus.gpu_transform_matrix[5]), 128);
        wait_idle("iso_a_idle", 200);
        exp_fc += 1;
        check_eq("iso_m5_after", 64'(bus.gpu_transform_matrix[5]), 128);
        // Write landing in the LAUNCH cycle
        pulse_single();
        vblank  = 1'b1;
        vbl_cyc = cyc;
        tick();
        write_cfg(5'd5, 32'd99);
        tick();
        vblank = 1'b0;
        wait_idle("iso_b_idle", 200);
        exp_fc += 1;
        check_eq("iso_b_cap_m5", cap_m5, 77);
        check_eq("iso_b_m5", 64'(bus.gpu_transform_matrix[5]), 77);
        pulse_single();
        vblank_edge(3);
        wait_idle("iso_c_idle", 200);
        exp_fc += 1;
        check_eq("iso_c_cap_m5", cap_m5, 99);
        check_eq("iso_c_cap_m0", cap_m0, 256);
        check_eq("iso_fc", 64'(frame_count), 64'(exp_fc));

        // Empty frame
        base_st = n_starts;
        write_cfg(5'd16, 32'd3);
        pulse_single();
        vblank_edge(3);
        wait_idle("empty_idle", 20);
        exp_fc += 1;
        check_eq("empty_starts", 64'(n_starts - base_st), 0);
        check_eq("empty_fc", 64'(frame_count), 64'(exp_fc));
        check_eq("empty_vc", 64'(bus.gpu_vertex_count), 3);

        // Timeout
        write_cfg(5'd16, 32'd100);
        gpu_hang = 1'b1;
        check_eq("to_err_pre", 64'(timeout_err), 0);
        pulse_single();
        vblank_edge(3);
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        check_eq("to_err_set", 64'(timeout_err), 1);
        check_eq("to_latency", 64'(cyc - start_cyc), 64);
        check_eq("to_fc", 64'(frame_count), 64'(exp_fc));
        check_eq("to_busy", 64'(busy), 0);
        tick();
        check_eq("to_err_sticky", 64'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("to_err_clr", 64'(timeout_err), 0);
        gpu_hang = 1'b0;

        // Reset mid-RUN, then identity-matrix frame
        gpu_lat = 50;
        pulse_single();
        vblank_edge(3);
        repeat (10) tick();
        check_eq("mid_busy", 64'(busy), 1);
        reset = 1'b1;
        tick();
        check_eq("mr_start", 64'(bus.gpu_start), 0);
        check_eq("mr_busy",  64'(busy), 0);
        check_eq("mr_fc",    64'(frame_count), 0);
        check_eq("mr_err",   64'(timeout_err), 0);
        check_eq("mr_vc",    64'(bus.gpu_vertex_count), 0);
        check_eq("mr_m0",    64'(bus.gpu_transform_matrix[0]), 128);
        check_eq("mr_m5",    64'(bus.gpu_transform_matrix[5]), 128);
        reset = 1'b0;
        tick();
        base_st = n_starts;
        write_cfg(5'd16, 32'd8);
        pulse_single();
        vblank_edge(3);
        wait_idle("post_idle", 200);
        check_eq("post_starts", 64'(n_starts - base_st), 1);
        check_eq("post_cap_m0", cap_m0, 128);
        check_eq("post_cap_m1", cap_m1, 0);
        check_eq("post_cap_m5", cap_m5, 128);
        check_eq("post_cap_vc", 64'(cap_vc), 8);
        check_eq("post_fc", 64'(frame_count), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpu_frame_sequencer.md
# gpu_frame_sequencer

Frame-level controller in front of the GPU top block. It holds double-buffered render configuration: a shadow transform matrix and vertex count written by the host, and an active copy driven to the GPU. It launches frames either once on request or continuously, each launch aligned to a display vblank rising edge. It commits shadow configuration only at launch, waits for the GPU frame-end handshake, guards each frame with a timeout, and counts completed frames.

## Interface
- MAT_W, 18, width of each signed transform-matrix entry
- FRAC_BITS, 7, fraction bits of matrix entries; identity diagonal value = 1<<FRAC_BITS
- TIMEOUT_CYCLES, 16777215, maximum cycles from launch to frame end
- USE_VBLANK, 1, when 1 a launch waits for a vblank rising edge; when 0 it proceeds immediately

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cfg_wr_en  in  1  shadow config write strobe
- cfg_wr_addr  in  5  0–15: matrix entry (row-major); 16: vertex count; 17–31: ignored
- cfg_wr_data  in  32  write data; matrix entries take bits [MAT_W-1:0]
- run  in  1  level, continuous mode
- single_shot  in  1  pulse, request one frame
- vblank  in  1  display blanking level
- err_clr  in  1  pulse, clears timeout_err
- gpu_frame_end  in  1  GPU frame-end flag
- gpu_start  out  1  one-cycle launch pulse to GPU
- gpu_vertex_count  out  32  active vertex count
- gpu_transform_matrix  out  16×MAT_W signed  active matrix, array [0:15]
- busy  out  1  high in any state except IDLE
- frame_count  out  32  completed or empty frames, wraps
- timeout_err  out  1  sticky timeout flag

## Operation
- States: IDLE, WAIT_VBL, LAUNCH, WAIT_ACK, RUN, DONE.
- IDLE → WAIT_VBL when run=1 or single_shot=1. single_shot outside IDLE is ignored.
- WAIT_VBL → LAUNCH on vblank & !vblank_q, where vblank_q is vblank registered one cycle. If USE_VBLANK=0, → LAUNCH the next cycle. Entering while vblank is already high waits for the next rising edge.
- LAUNCH (one cycle): copy shadow to active registers.
  - If shadow vertex count[31:2]==0 (fewer than 4 vertices): no gpu_start; → DONE as an empty frame.
  - Otherwise: gpu_start=1; → WAIT_ACK.
- WAIT_ACK: gpu_frame_end==0 → RUN.
- RUN: gpu_frame_end==1 → DONE.
- DONE (one cycle): frame_count+1. If run=1 → WAIT_VBL, else → IDLE.
- Timeout: a cycle counter clears in LAUNCH and increments in WAIT_ACK and RUN. When it reaches TIMEOUT_CYCLES: timeout_err←1, → IDLE, no frame_count increment.
- err_clr clears timeout_err. If err_clr and a timeout occur in the same cycle, the set wins.
- Shadow writes are accepted in any state.
  - A write in the LAUNCH cycle lands in shadow only; the active copy takes the pre-write shadow value, so the new value applies to the next frame.
  - Active registers change only in LAUNCH.
- run deasserted mid-frame: the current frame completes, then → IDLE.

## Timing
- Reset values:
  - state IDLE; gpu_start 0; busy 0; frame_count 0; timeout_err 0.
  - Shadow and active matrix: identity (diagonal entries 0,5,10,15 = 1<<FRAC_BITS, others 0).
  - Shadow and active vertex count: 0; vblank_q 0.
- Reset mid-frame returns everything to reset values in the next cycle; no gpu_start is issued in that cycle.
- All outputs are registered.
  - gpu_start is high exactly one cycle; active config is valid in the same cycle as gpu_start.
  - The GPU drops gpu_frame_end one cycle after gpu_start.
- Latency: vblank rising edge at cycle t → vblank_q edge detected at t+1 → LAUNCH at t+1, gpu_start high at t+2.
- Back-to-back frames in continuous mode need at least one new vblank edge between launches.
- busy falls the cycle after DONE when returning to IDLE.

## Test plan
- Single shot: write vertex count 100 and matrix entry 0 = 256, pulse single_shot, raise vblank → one gpu_start; gpu_vertex_count=100 and entry 0=256 in the same cycle; GPU model raises frame_end 50 cycles later → frame_count=1, busy=0.
- Continuous: run=1, three vblank edges, each frame 20 cycles → exactly 3 gpu_start pulses, each 2 cycles after a vblank edge, frame_count=3. Hold vblank high 100 cycles → no extra launch.
- Shadow isolation: write matrix entry 5 = 77 mid-RUN → active entry 5 unchanged until the next LAUNCH. Write in the LAUNCH cycle → applied one frame later.
- Empty frame: vertex count 3 → no gpu_start, frame_count increments, state returns to IDLE.
- Timeout with TIMEOUT_CYCLES=64: GPU never raises frame_end → timeout_err=1 exactly 64 cycles after entering WAIT_ACK, frame_count unchanged, state IDLE. err_clr → timeout_err=0.
- Reset mid-RUN → all outputs at reset values next cycle. A subsequent single_shot launches a frame with the identity matrix.
